ndn_producer: RTL and testbench
===============================

# ndn_producer

Content-producer endpoint that sits at the far end of the NDN router's outgoing interface. It answers the router's forwarded interest (longest-matching prefix, length, ready strobe) from a small local content store. On a hit it returns a data packet on the router's data-input interface: prefix, length, valid, and one content byte per cycle. On a miss it reports the interest as unsatisfied. The store is loaded through a side port while the block is idle.

## Interface
Parameters:
- ENTRIES, 4: number of content-store entries, power of two ≥ 2.
- MAX_BYTES, 16: maximum content bytes per entry, ≤ 63.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- interest_valid  in  1  router forwarded an interest (router `ready_for_data`).
- interest_prefix  in  64  router `longest_matching_prefix`, MSB-first.
- interest_len  in  6  router `longest_matching_prefix_len`, valid bits from MSB (0–63).
- ld_entry_we  in  1  write entry header.
- ld_byte_we  in  1  write one content byte.
- ld_idx  in  clog2(ENTRIES)  entry index for either write.
- ld_prefix  in  64  header prefix.
- ld_len  in  6  header prefix length.
- ld_clen  in  clog2(MAX_BYTES+1)  content length in bytes; 0 invalidates the entry.
- ld_addr  in  clog2(MAX_BYTES)  byte address.
- ld_byte  in  8  byte data.
- busy  out  1  high whenever not IDLE.
- data_ready  out  1  data byte valid (router `data_ready`).
- data_byte  out  8  content byte (router `in_data`).
- data_prefix  out  64  satisfied prefix, held for the whole packet.
- data_len  out  6  satisfied prefix length, held for the whole packet.
- hit  out  1  one-cycle pulse when a match is found.
- miss  out  1  one-cycle pulse when no entry matches.

## Operation
- FSM states:
  - IDLE: `interest_valid` latches prefix and length; idx←0; go to SEARCH.
  - SEARCH: compare entry idx once per cycle.
  - SEND: stream the matched entry's bytes.
- Match rule: entry `clen≠0` AND entry `len == interest_len` AND masked prefixes equal, with mask = ~(all-ones >> len). `len=0` therefore matches any prefix.
- Search order and outcome:
  - Entries are searched in order 0..ENTRIES-1; the lowest index hit wins.
  - On a hit: pulse `hit`; load `data_prefix`/`data_len`/`data_byte`=byte[0]; set `data_ready`=1; go to SEND with cnt=1.
  - If the last entry misses: pulse `miss` and return to IDLE.
- SEND: each cycle `data_byte`←byte[cnt], cnt++. After byte `clen-1` has been presented, `data_ready`←0 and the FSM returns to IDLE.
- `data_prefix`/`data_len` hold their value until the next hit.
- `interest_valid` outside IDLE is ignored; interests are not queued.
- Loads are accepted only when `busy=0` and are ignored otherwise.
  - `ld_entry_we` and `ld_byte_we` may be asserted together.
  - A load and `interest_valid` in the same IDLE cycle: the write takes effect and the search sees the new contents.
- Entry `ld_addr ≥ MAX_BYTES` cannot occur (address width); bytes beyond `clen` are don't-care.

## Timing
- All outputs are registered.
- Reset values: `busy`=0, `data_ready`=0, `data_byte`=0, `data_prefix`=0, `data_len`=0, `hit`=0, `miss`=0. All entry `clen` values clear to 0.
- `interest_valid` sampled at edge T:
  - hit at entry k: `hit` and the first byte appear in cycle T+2+k, and the last byte appears in cycle T+1+k+clen.
  - no match: `miss` pulses in cycle T+1+ENTRIES.
- `busy` rises in cycle T+1 and falls in the cycle after the last byte, or in the cycle after `miss`.
- `data_ready` is contiguous for exactly `clen` cycles; there is no backpressure.
- Back-to-back: a new interest is accepted in the first IDLE cycle.
- Reset asserted mid-SEND: `data_ready` drops immediately (asynchronously), the FSM goes to IDLE, and the store is invalidated.

## Structure
- Shared package `ndn_pkg`:
  - PREFIX_W=64, LEN_W=6, BYTE_W=8.
  - `state_t` enum {IDLE, SEARCH, SEND}.
  - `prefix_mask(len)` function, shared with the FIB/PIT match logic.
- One sub-module, `ndn_content_store`: register-array headers and bytes, two write ports, combinational header read by idx, and a combinational byte read by (idx, cnt).
- FSM, counters and output registers live in `ndn_producer`.

## Test plan
- Exact hit:
  - Setup: entry 2 = {prefix 64'hABCD_0000_0000_0000, len 16, clen 3, bytes 11,22,33}.
  - Stimulus: interest 64'hABCD_FFFF_FFFF_FFFF, len 16.
  - Required: `hit` at T+4; `data_byte` 11,22,33 in cycles T+4..T+6; `data_prefix` = 64'hABCD_0000_0000_0000.
- Miss:
  - Stimulus: interest len 17, otherwise the same as the exact-hit case.
  - Required: `miss` at T+5 (ENTRIES=4), `data_ready` never rises.
- Priority and invalid entries:
  - Setup: entries 0 and 3 identical, entry 0 `clen`=0.
  - Required: entry 3 is streamed.
- Busy gating:
  - Stimulus: `interest_valid` and `ld_byte_we` during SEND.
  - Required: both ignored; streamed bytes unchanged; next interest accepted at the first IDLE cycle.
- Reset: `rst` low during the second byte → all outputs 0 immediately; a subsequent interest misses.
- Boundary:
  - Stimulus: `clen`=MAX_BYTES=16, interest len 0.
  - Required: 16 contiguous bytes; len 0 matches any prefix.

Source files
------------

// File: rtl/ndn_producer_pkg.sv
// ============================================================================
// ndn_pkg : shared NDN widths, producer FSM states and prefix mask helper
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package ndn_pkg;

  localparam int PREFIX_W = 64;
  localparam int LEN_W    = 6;
  localparam int BYTE_W   = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    SEND   = 2'd2
  } state_t;

  // Keeps the top `len` bits of a prefix; len=0 yields an all-zero mask.
  function automatic logic [PREFIX_W-1:0] prefix_mask(input logic [LEN_W-1:0] len);
    prefix_mask = ~({PREFIX_W{1'b1}} >> len);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ndn_producer_if.sv
// ============================================================================
// ndn_producer_if : router interest/data, store load and status bundle
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface ndn_producer_if #(
  parameter int ENTRIES   = 4,
  parameter int MAX_BYTES = 16
);
  import ndn_pkg::*;

  localparam int IDX_W  = $clog2(ENTRIES);
  localparam int CLEN_W = $clog2(MAX_BYTES + 1);
  localparam int ADDR_W = $clog2(MAX_BYTES);

  logic                interest_valid;
  logic [PREFIX_W-1:0] interest_prefix;
  logic [LEN_W-1:0]    interest_len;
  logic                ld_entry_we;
  logic                ld_byte_we;
  logic [IDX_W-1:0]    ld_idx;
  logic [PREFIX_W-1:0] ld_prefix;
  logic [LEN_W-1:0]    ld_len;
  logic [CLEN_W-1:0]   ld_clen;
  logic [ADDR_W-1:0]   ld_addr;
  logic [BYTE_W-1:0]   ld_byte;
  logic                busy;
  logic                data_ready;
  logic [BYTE_W-1:0]   data_byte;
  logic [PREFIX_W-1:0] data_prefix;
  logic [LEN_W-1:0]    data_len;
  logic                hit;
  logic                miss;

  modport master (
    output interest_valid, interest_prefix, interest_len,
    output ld_entry_we, ld_byte_we, ld_idx, ld_prefix, ld_len, ld_clen, ld_addr, ld_byte,
    input  busy, data_ready, data_byte, data_prefix, data_len, hit, miss
  );

  modport slave (
    input  interest_valid, interest_prefix, interest_len,
    input  ld_entry_we, ld_byte_we, ld_idx, ld_prefix, ld_len, ld_clen, ld_addr, ld_byte,
    output busy, data_ready, data_byte, data_prefix, data_len, hit, miss
  );

endinterface

`default_nettype wire

// File: rtl/ndn_producer_content_store.sv
// ============================================================================
// ndn_content_store : register-array entry headers and content bytes
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module ndn_content_store
  import ndn_pkg::*;
#(
  parameter int ENTRIES   = 4,
  parameter int MAX_BYTES = 16,
  parameter int IDX_W     = $clog2(ENTRIES),
  parameter int CLEN_W    = $clog2(MAX_BYTES + 1),
  parameter int ADDR_W    = $clog2(MAX_BYTES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_we_hdr,
  input  logic                i_we_byte,
  input  logic [IDX_W-1:0]    i_wr_idx,
  input  logic [PREFIX_W-1:0] i_wr_prefix,
  input  logic [LEN_W-1:0]    i_wr_len,
  input  logic [CLEN_W-1:0]   i_wr_clen,
  input  logic [ADDR_W-1:0]   i_wr_addr,
  input  logic [BYTE_W-1:0]   i_wr_byte,
  input  logic [IDX_W-1:0]    i_rd_idx,
  input  logic [ADDR_W-1:0]   i_rd_addr,
  output logic [PREFIX_W-1:0] o_rd_prefix,
  output logic [LEN_W-1:0]    o_rd_len,
  output logic [CLEN_W-1:0]   o_rd_clen,
  output logic [BYTE_W-1:0]   o_rd_byte
);

  logic [PREFIX_W-1:0] prefix_q [ENTRIES];
  logic [LEN_W-1:0]    len_q    [ENTRIES];
  logic [CLEN_W-1:0]   clen_q   [ENTRIES];
  logic [BYTE_W-1:0]   bytes_q  [ENTRIES][MAX_BYTES];

  // Only clen is reset: a zero length is what marks an entry invalid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) clen_q[i] <= '0;
    end else if (i_we_hdr) begin
      clen_q[i_wr_idx] <= i_wr_clen;
    end
  end

  always_ff @(posedge clk) begin
    if (i_we_hdr) begin
      prefix_q[i_wr_idx] <= i_wr_prefix;
      len_q[i_wr_idx]    <= i_wr_len;
    end
    if (i_we_byte) bytes_q[i_wr_idx][i_wr_addr] <= i_wr_byte;
  end

  assign o_rd_prefix = prefix_q[i_rd_idx];
  assign o_rd_len    = len_q[i_rd_idx];
  assign o_rd_clen   = clen_q[i_rd_idx];
  assign o_rd_byte   = bytes_q[i_rd_idx][i_rd_addr];

endmodule

`default_nettype wire

// File: rtl/ndn_producer.sv
// ============================================================================
// ndn_producer : answers forwarded interests from a local content store
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module ndn_producer
  import ndn_pkg::*;
#(
  parameter int ENTRIES   = 4,
  parameter int MAX_BYTES = 16
) (
  input  logic          clk,
  input  logic          rst,
  ndn_producer_if.slave bus
);

  localparam int IDX_W  = $clog2(ENTRIES);
  localparam int CLEN_W = $clog2(MAX_BYTES + 1);
  localparam int ADDR_W = $clog2(MAX_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  state_t              state_q, state_d;
  logic [PREFIX_W-1:0] ip_q, ip_d;
  logic [LEN_W-1:0]    il_q, il_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CLEN_W-1:0]   cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                data_ready_q, data_ready_d;
  logic [BYTE_W-1:0]   data_byte_q, data_byte_d;
  logic [PREFIX_W-1:0] data_prefix_q, data_prefix_d;
  logic [LEN_W-1:0]    data_len_q, data_len_d;
  logic                hit_q, hit_d;
  logic                miss_q, miss_d;

  logic [PREFIX_W-1:0] w_e_prefix;
  logic [LEN_W-1:0]    w_e_len;
  logic [CLEN_W-1:0]   w_e_clen;
  logic [BYTE_W-1:0]   w_e_byte;
  logic                w_match;

  ndn_content_store #(
    .ENTRIES   (ENTRIES),
    .MAX_BYTES (MAX_BYTES)
  ) u_store (
    .clk         (clk),
    .rst         (rst),
    .i_we_hdr    (bus.ld_entry_we & ~busy_q),
    .i_we_byte   (bus.ld_byte_we & ~busy_q),
    .i_wr_idx    (bus.ld_idx),
    .i_wr_prefix (bus.ld_prefix),
    .i_wr_len    (bus.ld_len),
    .i_wr_clen   (bus.ld_clen),
    .i_wr_addr   (bus.ld_addr),
    .i_wr_byte   (bus.ld_byte),
    .i_rd_idx    (idx_q),
    .i_rd_addr   (cnt_q[ADDR_W-1:0]),
    .o_rd_prefix (w_e_prefix),
    .o_rd_len    (w_e_len),
    .o_rd_clen   (w_e_clen),
    .o_rd_byte   (w_e_byte)
  );

  assign w_match = (w_e_clen != '0) && (w_e_len == il_q) &&
                   (((w_e_prefix ^ ip_q) & prefix_mask(il_q)) == '0);

  always_comb begin
    state_d       = state_q;
    ip_d          = ip_q;
    il_d          = il_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    busy_d        = busy_q;
    data_ready_d  = data_ready_q;
    data_byte_d   = data_byte_q;
    data_prefix_d = data_prefix_q;
    data_len_d    = data_len_q;
    hit_d         = 1'b0;
    miss_d        = 1'b0;
    unique case (state_q)
      IDLE: begin
        // busy_q also covers the miss-pulse cycle, so nothing is accepted then.
        busy_d = 1'b0;
        if (bus.interest_valid && !busy_q) begin
          ip_d    = bus.interest_prefix;
          il_d    = bus.interest_len;
          idx_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (w_match) begin
          hit_d         = 1'b1;
          data_prefix_d = w_e_prefix;
          data_len_d    = w_e_len;
          data_byte_d   = w_e_byte;
          data_ready_d  = 1'b1;
          cnt_d         = CLEN_W'(1);
          state_d       = SEND;
        end else if (idx_q == LAST_IDX) begin
          miss_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      SEND: begin
        if (cnt_q == w_e_clen) begin
          data_ready_d = 1'b0;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end else begin
          data_byte_d = w_e_byte;
          cnt_d       = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      ip_q          <= '0;
      il_q          <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      data_ready_q  <= 1'b0;
      data_byte_q   <= '0;
      data_prefix_q <= '0;
      data_len_q    <= '0;
      hit_q         <= 1'b0;
      miss_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ip_q          <= ip_d;
      il_q          <= il_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
      data_ready_q  <= data_ready_d;
      data_byte_q   <= data_byte_d;
      data_prefix_q <= data_prefix_d;
      data_len_q    <= data_len_d;
      hit_q         <= hit_d;
      miss_q        <= miss_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.data_ready  = data_ready_q;
  assign bus.data_byte   = data_byte_q;
  assign bus.data_prefix = data_prefix_q;
  assign bus.data_len    = data_len_q;
  assign bus.hit         = hit_q;
  assign bus.miss        = miss_q;

endmodule

`default_nettype wire

// File: tb/tb_ndn_producer.sv
// ============================================================================
// tb_ndn_producer : directed stimulus with a queue-based event scoreboard
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ndn_producer;

  localparam int ENTRIES   = 4;
  localparam int MAX_BYTES = 16;
  localparam int EV_HIT    = 0;
  localparam int EV_BYTE   = 1;
  localparam int EV_MISS   = 2;

  typedef struct {
    int          kind;
    int          cyc;
    logic [7:0]  b;
    logic [63:0] p;
    logic [5:0]  l;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  ev_t        sb[$];
  logic [7:0] exp_b [16];

  ndn_producer_if #(.ENTRIES(ENTRIES), .MAX_BYTES(MAX_BYTES)) bus ();

  ndn_producer #(.ENTRIES(ENTRIES), .MAX_BYTES(MAX_BYTES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  task automatic check_ev(input int kind, input logic [7:0] b);
    ev_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: actual kind=%0d cyc=%0d byte=%h required no event", kind, cyc, b);
      return;
    end
    e = sb.pop_front();
    if (e.kind != kind || e.cyc != cyc || (kind == EV_BYTE && e.b !== b) ||
        (kind == EV_HIT && (e.p !== bus.data_prefix || e.l !== bus.data_len))) begin
      fails++;
      $display("FAIL event: actual kind=%0d cyc=%0d byte=%h prefix=%h len=%0d required kind=%0d cyc=%0d byte=%h prefix=%h len=%0d",
               kind, cyc, b, bus.data_prefix, bus.data_len, e.kind, e.cyc, e.b, e.p, e.l);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.hit)        check_ev(EV_HIT, 8'h00);
      if (bus.data_ready) check_ev(EV_BYTE, bus.data_byte);
      if (bus.miss)       check_ev(EV_MISS, 8'h00);
    end
  end

  task automatic push(input int kind, input int c, input logic [7:0] b,
                      input logic [63:0] p, input logic [5:0] l);
    ev_t e;
    e.kind = kind; e.cyc = c; e.b = b; e.p = p; e.l = l;
    sb.push_back(e);
  endtask

  task automatic expect_hit(input int k, input int n0, input logic [63:0] p,
                            input logic [5:0] l, input int clen);
    push(EV_HIT, n0 + 1 + k, 8'h00, p, l);
    for (int i = 0; i < clen; i++) push(EV_BYTE, n0 + 1 + k + i, exp_b[i], p, l);
  endtask

  task automatic expect_miss(input int n0);
    push(EV_MISS, n0 + ENTRIES, 8'h00, 64'h0, 6'd0);
  endtask

  task automatic load_hdr(input logic [1:0] idx, input logic [63:0] p,
                          input logic [5:0] l, input logic [4:0] c);
    @(negedge clk);
    bus.ld_entry_we = 1'b1; bus.ld_idx = idx; bus.ld_prefix = p; bus.ld_len = l; bus.ld_clen = c;
    @(negedge clk);
    bus.ld_entry_we = 1'b0;
  endtask

  task automatic load_byte(input logic [1:0] idx, input logic [3:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.ld_byte_we = 1'b1; bus.ld_idx = idx; bus.ld_addr = a; bus.ld_byte = b;
    @(negedge clk);
    bus.ld_byte_we = 1'b0;
  endtask

  // Returns the count of the edge that samples the interest.
  task automatic start(input logic [63:0] p, input logic [5:0] l, output int n0);
    @(negedge clk);
    bus.interest_valid = 1'b1; bus.interest_prefix = p; bus.interest_len = l;
    n0 = cyc + 1;
    @(negedge clk);
    bus.interest_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while ((sb.size() != 0 || bus.busy) && w < 200) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    tests++;
    if (sb.size() != 0 || bus.busy) begin
      fails++;
      $display("FAIL drain_timeout: actual pending=%0d busy=%b required pending=0 busy=0", sb.size(), bus.busy);
      sb.delete();
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"},   64'(bus.busy), 64'h0);
    chk({tag, "_ready"},  64'(bus.data_ready), 64'h0);
    chk({tag, "_byte"},   64'(bus.data_byte), 64'h0);
    chk({tag, "_prefix"}, bus.data_prefix, 64'h0);
    chk({tag, "_len"},    64'(bus.data_len), 64'h0);
    chk({tag, "_hit"},    64'(bus.hit), 64'h0);
    chk({tag, "_miss"},   64'(bus.miss), 64'h0);
  endtask

  task automatic set_abc();
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
  endtask

  initial begin
    int n0, n1;
    bus.interest_valid = 1'b0; bus.interest_prefix = '0; bus.interest_len = '0;
    bus.ld_entry_we = 1'b0; bus.ld_byte_we = 1'b0; bus.ld_idx = '0; bus.ld_prefix = '0;
    bus.ld_len = '0; bus.ld_clen = '0; bus.ld_addr = '0; bus.ld_byte = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;

    load_hdr(2'd0, 64'h1234_0000_0000_0000, 6'd16, 5'd2);
    load_hdr(2'd2, 64'hABCD_0000_0000_0000, 6'd16, 5'd3);
    load_byte(2'd2, 4'd0, 8'h11);
    load_byte(2'd2, 4'd1, 8'h22);
    load_byte(2'd2, 4'd2, 8'h33);

    // Exact hit at entry 2
    set_abc();
    start(64'hABCD_FFFF_FFFF_FFFF, 6'd16, n0);
    expect_hit(2, n0, 64'hABCD_0000_0000_0000, 6'd16, 3);
    drain();

    // Length mismatch misses
    start(64'hABCD_FFFF_FFFF_FFFF, 6'd17, n0);
    expect_miss(n0);
    drain();

    // Interest and byte load during SEND are ignored; held interest taken at first IDLE cycle
    start(64'hABCD_FFFF_FFFF_FFFF, 6'd16, n0);
    expect_hit(2, n0, 64'hABCD_0000_0000_0000, 6'd16, 3);
    n1 = n0 + 7;
    expect_hit(2, n1, 64'hABCD_0000_0000_0000, 6'd16, 3);
    while (cyc != n0 + 3) @(negedge clk);
    bus.interest_valid = 1'b1;
    bus.ld_byte_we = 1'b1; bus.ld_idx = 2'd2; bus.ld_addr = 4'd1; bus.ld_byte = 8'hEE;
    @(negedge clk);
    bus.ld_byte_we = 1'b0;
    while (cyc != n1) @(negedge clk);
    bus.interest_valid = 1'b0;
    drain();

    // Priority: entry 0 identical but invalid, entry 3 streams
    load_hdr(2'd0, 64'h5555_0000_0000_0000, 6'd8, 5'd0);
    load_byte(2'd0, 4'd0, 8'h99);
    load_hdr(2'd3, 64'h5555_0000_0000_0000, 6'd8, 5'd2);
    load_byte(2'd3, 4'd0, 8'hA1);
    load_byte(2'd3, 4'd1, 8'hA2);
    exp_b[0] = 8'hA1; exp_b[1] = 8'hA2;
    start(64'h55FF_0000_1111_2222, 6'd8, n0);
    expect_hit(3, n0, 64'h5555_0000_0000_0000, 6'd8, 2);
    drain();
    chk("prefix_hold", bus.data_prefix, 64'h5555_0000_0000_0000);
    chk("len_hold", 64'(bus.data_len), 64'd8);

    // Full-length entry with len 0 matches any prefix
    load_hdr(2'd1, 64'hFEED_0000_0000_0000, 6'd0, 5'd16);
    for (int i = 0; i < 16; i++) begin
      load_byte(2'd1, 4'(i), 8'(8'h80 + i));
      exp_b[i] = 8'(8'h80 + i);
    end
    start(64'hDEAD_BEEF_0123_4567, 6'd0, n0);
    expect_hit(1, n0, 64'hFEED_0000_0000_0000, 6'd0, 16);
    drain();

    // Reset during the second byte clears outputs and the store
    set_abc();
    start(64'hABCD_1234_0000_0000, 6'd16, n0);
    expect_hit(2, n0, 64'hABCD_0000_0000_0000, 6'd16, 3);
    while (cyc != n0 + 4) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_zero("midsend_reset");
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    start(64'hABCD_1234_0000_0000, 6'd16, n0);
    expect_miss(n0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual still running required finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
